// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: operation codes, FSM state type,
// access-size type and small decode helpers used by the FSM and the lane aligner.
package lsu_pkg;

  // Operation codes carried on req_op; 8..15 are illegal.
  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_SB  = 4'd5;
  localparam logic [3:0] OP_SH  = 4'd6;
  localparam logic [3:0] OP_SW  = 4'd7;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord
  } size_e;

  function automatic logic is_load(logic [3:0] op);
    return op <= OP_LHU;
  endfunction

  function automatic logic is_store(logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic size_e access_size(logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SzByte;
      OP_LH, OP_LHU, OP_SH: return SzHalf;
      default:              return SzWord;
    endcase
  endfunction

  // Byte accesses can never be misaligned.
  function automatic logic misaligned(logic [3:0] op, logic [1:0] byte_off);
    case (access_size(op))
      SzHalf:  return byte_off[0];
      SzWord:  return byte_off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response bus between the execute stage and the load/store unit.
//   master: drives req_valid/req_op/req_addr/req_wdata, observes busy and response.
//   slave:  the load/store unit side.
interface lsu_if;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    input  busy, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    output busy, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane handling for the load/store unit.
//   op          operation code
//   byte_off    address bits [1:0]
//   word_in     word read from memory
//   store_data  store data (low byte/halfword used for SB/SH)
//   load_value  selected lane, sign- or zero-extended (LW passes the word)
//   merged_word word_in with the target lane replaced (SW passes store_data)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word_in,
  input  logic [31:0] store_data,
  output logic [31:0] load_value,
  output logic [31:0] merged_word
);

  logic [4:0]  shamt;
  logic [15:0] lane;

  assign shamt = {byte_off, 3'b000};
  assign lane  = 16'(word_in >> shamt);

  always_comb begin
    load_value = word_in;
    case (op)
      OP_LB:   load_value = {{24{lane[7]}}, lane[7:0]};
      OP_LBU:  load_value = {24'h0, lane[7:0]};
      OP_LH:   load_value = {{16{lane[15]}}, lane[15:0]};
      OP_LHU:  load_value = {16'h0, lane[15:0]};
      default: load_value = word_in;
    endcase
  end

  always_comb begin
    merged_word = store_data;
    case (op)
      OP_SB: merged_word = (word_in & ~(32'h0000_00ff << shamt))
                         | ({24'h0, store_data[7:0]} << shamt);
      OP_SH: merged_word = (word_in & ~(32'h0000_ffff << shamt))
                         | ({16'h0, store_data[15:0]} << shamt);
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word load and store requests into
// word-wide accesses on a 2**ADDR_W x 32 data memory with combinational read.
//   clk, rst   clock, synchronous active-high reset
//   bus        request/response interface (slave side)
//   mem_addr   word index (latched addr[ADDR_W+1:2]); meaningful in READ/WRITE
//   mem_we     one-cycle write strobe, suppressed while rst is high
//   mem_wdata  word to write
//   mem_rdata  read data for mem_addr
// Sub-word stores do read-modify-write: READ captures the merged word, WRITE
// stores it. Illegal or misaligned requests go straight to DONE with resp_err.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  lsu_if.slave              bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_err;
  logic [31:0]       load_value;
  logic [31:0]       merged_word;

  // Upper address bits wrap around the memory and are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  assign req_err = !(is_load(bus.req_op) || is_store(bus.req_op))
                || misaligned(bus.req_op, bus.req_addr[1:0]);

  lsu_align u_align (
    .op          (op_q),
    .byte_off    (addr_q[1:0]),
    .word_in     (mem_rdata),
    .store_data  (wdata_q),
    .load_value  (load_value),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          addr_d  = bus.req_addr[ADDR_W+1:0];
          wdata_d = bus.req_wdata;
          rdata_d = '0;  // stores and errors respond with zero data
          err_d   = req_err;
          if (req_err) begin
            state_d = StDone;
          end else if (bus.req_op == OP_SW) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (is_load(op_q)) begin
          rdata_d = load_value;
          state_d = StDone;
        end else begin
          wdata_d = merged_word;
          state_d = StWrite;
        end
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.resp_valid = (state_q == StDone);
  assign bus.resp_err   = (state_q == StDone) && err_q;
  assign bus.resp_rdata = rdata_q;

  assign mem_addr  = addr_q[ADDR_W+1:2];
  assign mem_we    = (state_q == StWrite) && !rst;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int AW    = 5;
  localparam int WORDS = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  int resp_cnt = 0;
  logic [AW-1:0] we_addr;
  logic [31:0]   we_data;

  lsu_if bus ();

  load_store_unit #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt        <= we_cnt + 1;
      we_addr       <= mem_addr;
      we_data       <= mem_wdata;
    end
    if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour from the architectural rules, using plain arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output logic err, output int lat, output logic we,
                                output int widx, output logic [31:0] wword);
    longint unsigned w, scale, unit, v, oldl, newl, nw;
    int k, sz;
    widx  = int'((addr / 4) % WORDS);
    k     = int'(addr % 4);
    w     = longint'(ref_mem[widx]);
    sz    = (op == 0 || op == 3 || op == 5) ? 1 : (op == 1 || op == 4 || op == 6) ? 2 : 4;
    scale = longint'(1) << (8 * k);
    unit  = (sz == 1) ? 256 : 65536;
    rd = 0; we = 0; wword = 0;
    err = (op > 7) || (addr % sz != 0);
    if (err) begin
      lat = 1;
      return;
    end
    if (op <= 4) begin
      lat = 2;
      v = (op == 2) ? w : (w / scale) % unit;
      if (op == 0 && v >= 128)   v = v + 64'hFFFF_FF00;
      if (op == 1 && v >= 32768) v = v + 64'hFFFF_0000;
      rd = v[31:0];
    end else begin
      lat = (op == 7) ? 2 : 3;
      if (op == 7) begin
        nw = longint'(wd);
      end else begin
        oldl = (w / scale) % unit;
        newl = longint'(wd) % unit;
        nw   = w - oldl * scale + newl * scale;
      end
      we    = 1;
      wword = nw[31:0];
      ref_mem[widx] = wword;
    end
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd);
    logic [31:0] erd, ewd;
    logic eerr, ewe;
    int elat, eidx, lat, we0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    model(op, addr, wd, erd, eerr, elat, ewe, eidx, ewd);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    we0 = we_cnt;
    check({tag, " busy"}, 32'(bus.busy), 32'd1);
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " rdata"}, bus.resp_rdata, erd);
    check({tag, " err"}, 32'(bus.resp_err), 32'(eerr));
    check({tag, " writes"}, we_cnt - we0, ewe ? 1 : 0);
    if (ewe) begin
      check({tag, " waddr"}, 32'(we_addr), eidx);
      check({tag, " wdata"}, we_data, ewd);
    end
    @(posedge clk);
    #1;
    check({tag, " resp pulse"}, 32'(bus.resp_valid), 32'd0);
    check({tag, " idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] erd, ewd, a;
    logic eerr, ewe;
    logic [3:0] op;
    int elat, eidx, r0, w0, lat;

    for (int i = 0; i < WORDS; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[3] = 32'h8077_F0A5; ref_mem[3] = 32'h8077_F0A5;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 32'(bus.busy), 0);
    check("rst resp_valid", 32'(bus.resp_valid), 0);
    check("rst resp_err", 32'(bus.resp_err), 0);
    check("rst resp_rdata", bus.resp_rdata, 0);
    check("rst mem_we", 32'(mem_we), 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst mem_addr", 32'(mem_addr), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed sub-word loads.
    run_op("lb", 4'd0, 32'h0C, 32'h0);
    check("lb value", bus.resp_rdata, 32'hFFFF_FFA5);
    run_op("lbu", 4'd3, 32'h0D, 32'h0);
    run_op("lh", 4'd1, 32'h0E, 32'h0);
    run_op("lhu", 4'd4, 32'h0E, 32'h0);
    // Word store then load back.
    run_op("sw", 4'd7, 32'h10, 32'hDEAD_BEEF);
    run_op("lw", 4'd2, 32'h10, 32'h0);
    // Read-modify-write stores.
    mem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
    run_op("sb", 4'd5, 32'h11, 32'h0000_00AB);
    check("sb word", mem[4], 32'h1122_AB44);
    run_op("sh", 4'd6, 32'h12, 32'h0000_CAFE);
    check("sh word", mem[4], 32'hCAFE_AB44);
    // Error cases.
    run_op("lw mis", 4'd2, 32'h06, 32'h0);
    run_op("sh mis", 4'd6, 32'h03, 32'h1234);
    run_op("illegal", 4'd9, 32'h10, 32'h0);

    // Reset during the WRITE cycle of an SB.
    r0 = resp_cnt; w0 = we_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 4'd5; bus.req_addr = 32'h14; bus.req_wdata = 32'h77;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("rmw in write", 32'(mem_we), 1);
    rst = 1'b1;
    #1;
    check("rst gates we", 32'(mem_we), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst abort busy", 32'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst abort resp", resp_cnt - r0, 0);
    check("rst abort writes", we_cnt - w0, 0);
    check("rst abort mem", mem[5], ref_mem[5]);

    // Request held across a busy load with a different op.
    r0 = resp_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 4'd0; bus.req_addr = 32'h0C; bus.req_wdata = 0;
    model(4'd0, 32'h0C, 0, erd, eerr, elat, ewe, eidx, ewd);
    @(posedge clk); #1;
    bus.req_op = 4'd2; bus.req_addr = 32'h10;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    check("hold first lat", lat, 2);
    check("hold first data", bus.resp_rdata, erd);
    model(4'd2, 32'h10, 0, erd, eerr, elat, ewe, eidx, ewd);
    @(posedge clk); #1;
    check("hold idle gap", 32'(bus.busy), 0);
    @(posedge clk); #1;
    check("hold second accept", 32'(bus.busy), 1);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("hold second valid", 32'(bus.resp_valid), 1);
    check("hold second data", bus.resp_rdata, erd);
    @(posedge clk); #1;
    check("hold resp count", resp_cnt - r0, 2);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = (op == 2 || op == 7) ? 2'b00 : {a[1], 1'b0};
      run_op("rand", op, a, $urandom);
    end
    for (int i = 0; i < WORDS; i++) check("final mem", mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the word-organised data memory. Converts MIPS load/store requests (LW, LH, LHU, LB, LBU, SW, SH, SB) into word-wide memory accesses.
- Performs sub-word extraction with sign or zero extension, and read-modify-write for byte/halfword stores.
- Flags misaligned or illegal requests and stalls the pipeline while an access is in flight.

Parameters:
- ADDR_W, 5, word-index width of the data memory (2**ADDR_W words of 32 bits).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present; sampled only when busy=0.
- req_op  input  4  operation code (package constants).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; low byte/halfword used for SB/SH.
- busy  output  1  unit occupied; upstream holds or stalls.
- resp_valid  output  1  one-cycle pulse: access complete.
- resp_rdata  output  32  load result, extended; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid: misaligned or illegal op.
- mem_addr  output  ADDR_W  word index = addr[ADDR_W+1:2]; upper address bits ignored (wrap).
- mem_we  output  1  memory write enable, one cycle.
- mem_wdata  output  32  word to write.
- mem_rdata  input  32  combinational read data for mem_addr.

Behaviour:
- Byte order is little-endian: byte k occupies bits 8k+7:8k.
- FSM states: IDLE, READ, WRITE, DONE. busy = (state != IDLE).
- IDLE: on req_valid, latch op, addr and wdata at the edge. Next state:
  - err case (illegal op, or misalignment) -> DONE.
  - any load, SB or SH -> READ.
  - SW -> WRITE.
- Misalignment rules:
  - LW/SW: addr[1:0] != 0.
  - LH/LHU/SH: addr[0] != 0.
  - Bytes: never misaligned.
- READ: mem_addr driven from the latched address; mem_rdata captured at the end of the cycle. Next state:
  - loads -> DONE; extracted and extended value registered into resp_rdata.
  - SB/SH -> WRITE; merged word registered (target lane replaced, other lanes preserved).
- WRITE: mem_we=1 for exactly one cycle. mem_wdata is req_wdata (SW) or the merged word (SB/SH). Next state DONE.
- DONE: resp_valid=1 and resp_err per latched check. Next state IDLE; a new request can be accepted in the following cycle.
- Latency from accept edge to resp_valid:
  - loads: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - errors: 1 cycle.
- Errors perform no memory access (mem_we stays 0).
- Requests while busy=1 are ignored and not queued.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Reset values: state IDLE, busy 0, resp_valid 0, resp_err 0, resp_rdata 0, mem_we 0, mem_wdata 0, mem_addr 0.
- Reset mid-operation: FSM returns to IDLE and no response is issued. mem_we is gated by !rst, so no write occurs in a cycle where rst=1, even from the WRITE state.
- mem_addr holds the last latched value outside READ/WRITE; it is only meaningful in those states.

Decomposition:
- Package lsu_pkg holds:
  - op codes: OP_LB=0, OP_LH=1, OP_LW=2, OP_LBU=3, OP_LHU=4, OP_SB=5, OP_SH=6, OP_SW=7; codes 8-15 illegal.
  - state enum.
  - helper functions is_load, is_store, access size.
- One combinational sub-module, lsu_align, does lane extraction/extension (load path) and lane merge (store path). It takes op, addr[1:0], word_in and store_data, and returns load_value and merged_word.
- FSM and registers live in load_store_unit.

Test Plan:
- Preload word 3 = 0x8077_F0A5. LB addr 0x0C -> resp_rdata 0xFFFF_FFA5 two cycles after accept; LBU addr 0x0D -> 0x0000_00F0; LH addr 0x0E -> 0xFFFF_8077; LHU addr 0x0E -> 0x0000_8077.
- SW addr 0x10, wdata 0xDEAD_BEEF -> mem_we one cycle with mem_addr=4; LW addr 0x10 returns 0xDEAD_BEEF, resp_err=0.
- Word 4 = 0x1122_3344. SB addr 0x11, wdata 0x0000_00AB -> written 0x1122_AB44. SH addr 0x12, wdata 0xCAFE -> word 0xCAFE_AB44. Latency 3 cycles each.
- LW addr 0x06, SH addr 0x03, op 9 -> each gives resp_valid after 1 cycle with resp_err=1, resp_rdata=0, no mem_we.
- Issue SB, assert rst during the WRITE cycle -> no mem_we, no resp_valid, busy=0 next cycle, memory word unchanged.
- Hold req_valid across a busy load with a different op -> only the first request is executed. The second is accepted only once busy=0.
